// File: rtl/execution_controller.sv
// Run controller for a processor instance: sequences the processor reset, counts RUN cycles,
// detects the HALT rising edge, enforces a cycle-count timeout and holds a post-halt drain
// window. START restarts the whole sequence from either DONE state without a global reset.
module execution_controller #(
    parameter int unsigned RESET_CYCLES     = 10,
    parameter int unsigned TIMEOUT_CYCLES   = 2500000,
    parameter int unsigned POST_HALT_CYCLES = 5,
    parameter int unsigned COUNT_WIDTH      = 32
) (
    input  logic                   CLK,
    input  logic                   RST_bar,
    input  logic                   HALT,
    input  logic                   START,
    output logic                   CPU_RST_bar,
    output logic                   RUNNING,
    output logic                   HALTED,
    output logic                   TIMED_OUT,
    output logic                   DONE,
    output logic [COUNT_WIDTH-1:0] CYCLES
);

    // One counter serves both the reset hold and the drain window; size it for the longer one.
    localparam int unsigned CntMax = (RESET_CYCLES > POST_HALT_CYCLES) ? RESET_CYCLES
                                                                       : POST_HALT_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0]        HoldLast    = CntW'(RESET_CYCLES - 1);
    localparam logic [CntW-1:0]        DrainLast   = CntW'(POST_HALT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] TimeoutLast = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] TimeoutVal  = COUNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StResetHold   = 3'd0,
        StRun         = 3'd1,
        StDrain       = 3'd2,
        StDoneHalt    = 3'd3,
        StDoneTimeout = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] cycles_q, cycles_d;
    logic                   halt_prev_q;
    logic                   halt_rise;
    logic                   cpu_rst_bar_q, cpu_rst_bar_d;
    logic                   running_q, running_d;
    logic                   halted_q, halted_d;
    logic                   timed_out_q, timed_out_d;
    logic                   done_q, done_d;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cycles_d  = cycles_q;
        halt_rise = HALT & ~halt_prev_q;

        case (state_q)
            StResetHold: begin
                if (cnt_q == HoldLast) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    cycles_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                // Halt wins over a timeout landing on the same edge.
                if (halt_rise) begin
                    cnt_d   = '0;
                    state_d = (POST_HALT_CYCLES == 0) ? StDoneHalt : StDrain;
                end else if ((TIMEOUT_CYCLES != 0) && (cycles_q == TimeoutLast)) begin
                    cycles_d = TimeoutVal;
                    state_d  = StDoneTimeout;
                end else if (cycles_q != '1) begin
                    cycles_d = cycles_q + COUNT_WIDTH'(1);
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    state_d = StDoneHalt;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDoneHalt, StDoneTimeout: begin
                // CYCLES is kept until the next RUN entry clears it.
                if (START) begin
                    state_d = StResetHold;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StResetHold;
                cnt_d   = '0;
            end
        endcase

        // Timeout pulls the processor back into reset so a runaway program stops.
        cpu_rst_bar_d = (state_d == StRun) || (state_d == StDrain) || (state_d == StDoneHalt);
        running_d     = (state_d == StRun);
        halted_d      = (state_d == StDoneHalt);
        timed_out_d   = (state_d == StDoneTimeout);
        done_d        = halted_d | timed_out_d;
    end

    // State and output registers; halt_prev resets high so a HALT held through reset is no rise.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state_q       <= StResetHold;
            cnt_q         <= '0;
            cycles_q      <= '0;
            halt_prev_q   <= 1'b1;
            cpu_rst_bar_q <= 1'b0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
            timed_out_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cycles_q      <= cycles_d;
            halt_prev_q   <= HALT;
            cpu_rst_bar_q <= cpu_rst_bar_d;
            running_q     <= running_d;
            halted_q      <= halted_d;
            timed_out_q   <= timed_out_d;
            done_q        <= done_d;
        end
    end

    assign CPU_RST_bar = cpu_rst_bar_q;
    assign RUNNING     = running_q;
    assign HALTED      = halted_q;
    assign TIMED_OUT   = timed_out_q;
    assign DONE        = done_q;
    assign CYCLES      = cycles_q;

endmodule

// File: doc/execution_controller.md
Name: execution_controller

Overview:
- Synthesisable run controller for a processor instance; the parametrised successor to the bench-level clock/reset/timeout/HALT harness.
- Sequences the processor reset, counts executed cycles, detects HALT, enforces a cycle-count timeout and holds a post-halt drain window.
- Supports restart via START, so a bench or on-board host runs repeated programs without global reset.
- Sits between the board/bench reset and the processor RST_bar; status outputs feed the bench or board LEDs.

Parameters:
- RESET_CYCLES, 10, number of CLK posedges CPU_RST_bar is held low after RST_bar release or restart; must be >= 1.
- TIMEOUT_CYCLES, 2500000, RUN cycles before timeout is declared; 0 disables the timeout.
- POST_HALT_CYCLES, 5, drain cycles after the HALT rise before DONE asserts; 0 allowed.
- COUNT_WIDTH, 32, width of CYCLES; must hold TIMEOUT_CYCLES.

Ports:
- CLK  input  1  processor clock; all state changes on posedge.
- RST_bar  input  1  asynchronous active-low reset.
- HALT  input  1  processor halt line; synchronous to CLK.
- START  input  1  restart request; honoured only in DONE_HALT or DONE_TIMEOUT.
- CPU_RST_bar  output  1  registered reset to the processor, active low.
- RUNNING  output  1  high in RUN.
- HALTED  output  1  high in DONE_HALT.
- TIMED_OUT  output  1  high in DONE_TIMEOUT.
- DONE  output  1  HALTED | TIMED_OUT.
- CYCLES  output  COUNT_WIDTH  RUN cycle count; frozen outside RUN until the next restart.

Behaviour:
- Reset (RST_bar low, asynchronous):
  - state = RESET_HOLD, hold counter = 0, CYCLES = 0, halt_prev = 1.
  - CPU_RST_bar = 0; RUNNING, HALTED, TIMED_OUT and DONE are all 0.
  - Assertion mid-run aborts immediately, with no drain.
- All outputs are registered; no combinational path exists from inputs to outputs.
- Halt edge: halt_prev <= HALT on every posedge in all states. halt_rise = HALT & ~halt_prev. Because halt_prev resets to 1, a HALT held high through reset is not a rise.
- RESET_HOLD:
  - Hold counter increments each posedge.
  - On the posedge where hold counter == RESET_CYCLES-1: go to RUN, CPU_RST_bar <= 1, CYCLES <= 0, hold counter <= 0.
  - CPU_RST_bar therefore rises on the RESET_CYCLES-th posedge after release.
  - halt_rise and START are ignored in this state.
- RUN, with priority in this order:
  - halt_rise: go to DRAIN, CYCLES unchanged.
  - Else if TIMEOUT_CYCLES != 0 and CYCLES == TIMEOUT_CYCLES-1: CYCLES <= TIMEOUT_CYCLES and go to DONE_TIMEOUT.
  - Else CYCLES <= CYCLES+1, saturating at all-ones; no wrap.
  - A halt rise and a timeout on the same edge resolve as halt.
- DRAIN:
  - CPU_RST_bar stays 1; the drain counter counts POST_HALT_CYCLES posedges, then the state goes to DONE_HALT.
  - With POST_HALT_CYCLES == 0, RUN goes directly to DONE_HALT on the halt_rise edge.
  - Further HALT activity is ignored.
- DONE_HALT / DONE_TIMEOUT:
  - CPU_RST_bar: stays 1 in DONE_HALT; driven 0 on entry to DONE_TIMEOUT so a runaway program stops.
  - Status outputs hold.
  - START sampled high: go to RESET_HOLD, CPU_RST_bar <= 0, status outputs cleared, hold counter <= 0. CYCLES is retained until the RUN entry clears it.
  - START held high continuously is not a second restart until the state is DONE again.
- States are binary encoded. Illegal encodings return to RESET_HOLD on the next posedge.

Test Plan:
- Defaults except TIMEOUT_CYCLES=100, COUNT_WIDTH=16:
  - Release RST_bar → CPU_RST_bar low for exactly 10 posedges, then rises with RUNNING=1 and CYCLES=0.
  - HALT rises after 37 RUN cycles → CYCLES freezes at 37, RUNNING drops, HALTED and DONE rise 5 posedges later, CPU_RST_bar stays 1.
  - HALT never rises → on the 100th RUN posedge CYCLES=100, TIMED_OUT=1, DONE=1, CPU_RST_bar=0.
- HALT rises on the same edge CYCLES==99 would time out → DRAIN, then HALTED=1, TIMED_OUT=0, CYCLES=99.
- After DONE_HALT, pulse START for 1 cycle → status clears, 10-cycle reset hold, new run with CYCLES restarting at 0; a second HALT gives a fresh count.
- Edge and abort cases:
  - HALT held high through reset and the hold window → no halt detected; HALT must fall and rise again.
  - RST_bar asserted mid-RUN → all outputs reach reset values without waiting for CLK.
